// File: rtl/inert_spi_serf_pkg.sv
// Shared definitions for the inertial-sensor SPI responder: register map
// addresses, frame geometry and the frame FSM state encoding.
package inert_spi_pkg;

  localparam logic [6:0] ADDR_CFG_LAST = 7'h0E;
  localparam logic [6:0] ADDR_INT_CFG  = 7'h0D;
  localparam logic [6:0] ADDR_WHO      = 7'h0F;
  localparam logic [6:0] ADDR_PTCH_L   = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H   = 7'h23;

  localparam int         NUM_CFG    = 15;
  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic [4:0] ADDR_BITS  = 5'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic cfg_writable(input logic [6:0] addr);
    return (addr <= ADDR_CFG_LAST);
  endfunction

endpackage

// File: rtl/inert_spi_serf_if.sv
// SS_n/SCLK/MOSI/MISO/INT link between the SPI master and the sensor responder.
interface inert_spi_serf_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic INT;

  modport master (output SS_n, output SCLK, output MOSI, input MISO, input INT);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO, output INT);
endinterface

// File: rtl/inert_spi_serf_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with registered rise/fall pulses
// (pulse appears STAGES+1 clocks after the pin edge).
module spi_sync_edge #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;
  logic              rise_r;
  logic              fall_r;

  // Synchronizer chain plus one-clock edge pulses off its last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{RST_VAL}};
      prev_r <= RST_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
      rise_r <= sync_r[STAGES-1] & ~prev_r;
      fall_r <= ~sync_r[STAGES-1] & prev_r;
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/inert_spi_serf.sv
// SPI mode-0 responder for the inertial sensor: 16-bit frames, config/WHO_AM_I/
// pitch register map and a level interrupt on newly latched pitch samples.
module inert_spi_serf
  import inert_spi_pkg::*;
#(
  parameter int         SYNC_STAGES  = 3,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6A
) (
  input  logic              clk,
  input  logic              rst,
  inert_spi_serf_if.slave   bus,
  input  logic [15:0]       ptch_in,
  input  logic              sample_stb
);

  localparam logic [3:0] IDX_INT_CFG = ADDR_INT_CFG[3:0];

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic ss_lvl_s, ss_rise_s, ss_fall_s;
  logic mosi_s;

  logic [SYNC_STAGES-1:0] mosi_sync_r;
  state_t                 state_r;
  logic [4:0]             cnt_r;
  logic [15:0]            rx_r;
  logic [7:0]             tx_r;
  logic                   miso_r;
  logic                   int_r;
  logic [7:0]             cfg_r [0:NUM_CFG-1];
  logic [15:0]            shadow_r;
  logic [15:0]            stage_r;
  logic                   pend_r;

  logic [6:0]  rd_addr_s;
  logic [7:0]  rd_data_s;
  logic        frame_ok_s;
  logic        wr_s;
  logic        clr_s;
  logic        int_en_nxt_s;
  logic        cap_s;
  logic [15:0] cap_val_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.SCLK),
    .level (sclk_lvl_s),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.SS_n),
    .level (ss_lvl_s),
    .rise  (ss_rise_s),
    .fall  (ss_fall_s)
  );

  // MOSI only needs its level, sampled on the delayed SCLK rise pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.MOSI};
    end
  end

  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

  // Read mux for the address formed on the 8th SCLK rise (bit 8 is still in MOSI).
  always_comb begin
    rd_addr_s = {rx_r[5:0], mosi_s};
    rd_data_s = 8'h00;
    if (cfg_writable(rd_addr_s)) begin
      rd_data_s = cfg_r[rd_addr_s[3:0]];
    end else begin
      case (rd_addr_s)
        ADDR_WHO:    rd_data_s = WHO_AM_I_VAL;
        ADDR_PTCH_L: rd_data_s = shadow_r[7:0];
        ADDR_PTCH_H: rd_data_s = shadow_r[15:8];
        default:     rd_data_s = 8'h00;
      endcase
    end
  end

  // End-of-frame decisions; a strobe in the FINISH cycle itself is the newest sample.
  always_comb begin
    frame_ok_s   = (cnt_r == FRAME_BITS);
    wr_s         = frame_ok_s & ~rx_r[15] & cfg_writable(rx_r[14:8]);
    clr_s        = frame_ok_s & rx_r[15] & (rx_r[14:8] == ADDR_PTCH_H);
    int_en_nxt_s = cfg_r[IDX_INT_CFG][1];
    if (wr_s && (rx_r[14:8] == ADDR_INT_CFG)) begin
      int_en_nxt_s = rx_r[1];
    end else begin
      int_en_nxt_s = cfg_r[IDX_INT_CFG][1];
    end
    cap_s     = pend_r | sample_stb;
    cap_val_s = sample_stb ? ptch_in : stage_r;
  end

  // Frame FSM with registered MISO/INT and the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 5'd0;
      rx_r     <= 16'h0000;
      tx_r     <= 8'h00;
      miso_r   <= 1'b0;
      int_r    <= 1'b0;
      shadow_r <= 16'h0000;
      stage_r  <= 16'h0000;
      pend_r   <= 1'b0;
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_r[i] <= 8'h00;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          miso_r <= 1'b0;
          if (sample_stb) begin
            shadow_r <= ptch_in;
            if (cfg_r[IDX_INT_CFG][1]) begin
              int_r <= 1'b1;
            end
          end
          if (ss_fall_s) begin
            state_r <= ST_SHIFT;
            cnt_r   <= 5'd0;
            rx_r    <= 16'h0000;
            tx_r    <= 8'h00;
          end
        end
        ST_SHIFT: begin
          if (sample_stb) begin
            pend_r  <= 1'b1;
            stage_r <= ptch_in;
          end
          if (ss_rise_s) begin
            state_r <= ST_FINISH;
            miso_r  <= 1'b0;
          end else begin
            // A rise racing the SS_n release is not part of the frame.
            if (sclk_rise_s && !ss_lvl_s && (cnt_r != FRAME_BITS)) begin
              rx_r  <= {rx_r[14:0], mosi_s};
              cnt_r <= cnt_r + 5'd1;
              if (cnt_r == (ADDR_BITS - 5'd1)) begin
                tx_r <= rd_data_s;
              end
            end
            if (sclk_fall_s && !sclk_lvl_s && (cnt_r >= ADDR_BITS)) begin
              miso_r <= tx_r[7];
              tx_r   <= {tx_r[6:0], 1'b0};
            end
          end
        end
        ST_FINISH: begin
          miso_r  <= 1'b0;
          pend_r  <= 1'b0;
          state_r <= ST_IDLE;
          if (wr_s) begin
            cfg_r[rx_r[11:8]] <= rx_r[7:0];
          end
          if (cap_s) begin
            shadow_r <= cap_val_s;
          end
          if (cap_s && int_en_nxt_s) begin
            int_r <= 1'b1;
          end else if (clr_s || !int_en_nxt_s) begin
            int_r <= 1'b0;
          end else begin
            int_r <= int_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          miso_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MISO = miso_r;
  assign bus.INT  = int_r;

endmodule

// File: tb/tb_inert_spi_serf.sv
// Randomized scoreboard bench for inert_spi_serf: a bit-banged SPI master, a
// register-map reference model and a monitor that checks read frames on the bus.
module tb_inert_spi_serf;

  localparam int S  = 3;
  localparam int HP = S + 4;

  logic        clk;
  logic        rst;
  logic [15:0] ptch_in;
  logic        sample_stb;

  inert_spi_serf_if bus ();

  inert_spi_serf #(.SYNC_STAGES(S), .WHO_AM_I_VAL(8'h6A)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ptch_in    (ptch_in),
    .sample_stb (sample_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0]  exp_q [$];
  logic [7:0]  m_cfg [0:14];
  logic [15:0] m_shadow;
  logic        m_int;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a <= 7'h0E) return m_cfg[a[3:0]];
    if (a == 7'h0F) return 8'h6A;
    if (a == 7'h22) return m_shadow[7:0];
    if (a == 7'h23) return m_shadow[15:8];
    return 8'h00;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) m_cfg[i] = 8'h00;
    m_shadow = 16'h0000;
    m_int    = 1'b0;
  endtask

  task automatic pulse_stb(input logic [15:0] v);
    ptch_in    = v;
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
  endtask

  // Idle-time sample: latched at once, INT follows the enable bit.
  task automatic sample_idle(input logic [15:0] v);
    pulse_stb(v);
    m_shadow = v;
    if (m_cfg[13][1]) m_int = 1'b1;
    wait_clk(2);
    check("int_after_idle_sample", 32'(bus.INT), 32'(m_int));
  endtask

  // One master transaction; optionally cut short, strobed mid-frame or reset.
  task automatic spi_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                           input int nbits, input int stb_bit, input int n_stb,
                           input logic [15:0] stb_val, input int rst_bit);
    logic [15:0] word;
    logic [15:0] last_stb;
    logic        did_stb;
    word    = {rw, addr, data};
    did_stb = 1'b0;
    last_stb = 16'h0000;
    if (rw && nbits == 16 && rst_bit < 0) exp_q.push_back(m_read(addr));
    bus.SS_n = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst      = 1'b1;
        bus.SCLK = 1'b0;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        m_reset();
        wait_clk(2 * HP);
        return;
      end
      if (i == stb_bit) begin
        for (int k = 0; k < n_stb; k++) begin
          last_stb = stb_val + 16'(k);
          pulse_stb(last_stb);
          did_stb = 1'b1;
        end
      end
      bus.MOSI = word[15-i];
      wait_clk(HP);
      bus.SCLK = 1'b1;
      wait_clk(HP);
      bus.SCLK = 1'b0;
    end
    bus.MOSI = 1'b0;
    wait_clk(HP);
    bus.SS_n = 1'b1;
    wait_clk(2 * HP);
    if (nbits == 16) begin
      if (!rw && addr <= 7'h0E) begin
        m_cfg[addr[3:0]] = data;
        if (addr == 7'h0D && !data[1]) m_int = 1'b0;
      end
      if (rw && addr == 7'h23) m_int = 1'b0;
    end
    if (did_stb) begin
      m_shadow = last_stb;
      if (m_cfg[13][1]) m_int = 1'b1;
    end
    check("int_after_frame", 32'(bus.INT), 32'(m_int));
    check("miso_idle", 32'(bus.MISO), 32'd0);
  endtask

  task automatic rd(input logic [6:0] a);
    spi_frame(1'b1, a, 8'h00, 16, -1, 0, 16'h0000, -1);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    spi_frame(1'b0, a, d, 16, -1, 0, 16'h0000, -1);
  endtask

  // Bus monitor: collects MOSI/MISO per frame and scores complete reads.
  int          mon_bits;
  logic [15:0] mon_mo;
  logic [15:0] mon_mi;
  initial begin
    mon_bits = 0;
    mon_mo   = 16'h0000;
    mon_mi   = 16'h0000;
    fork
      forever begin
        @(negedge bus.SS_n);
        mon_bits = 0;
      end
      forever begin
        @(posedge bus.SCLK);
        if (bus.SS_n === 1'b0 && mon_bits < 16) begin
          mon_mo = {mon_mo[14:0], bus.MOSI};
          mon_mi = {mon_mi[14:0], bus.MISO};
          mon_bits++;
        end
      end
      forever begin
        @(posedge bus.SS_n);
        if (mon_bits == 16 && mon_mo[15]) begin
          if (exp_q.size() == 0) begin
            check("read_unexpected", 32'(mon_mi), 32'hFFFF_FFFF);
          end else begin
            check("read_data", 32'(mon_mi), {24'h0, exp_q.pop_front()});
          end
        end
        mon_bits = 0;
      end
    join_none
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] a;
    int         nb;
    int         sb;
    int         ns;
    rst        = 1'b1;
    bus.SS_n   = 1'b1;
    bus.SCLK   = 1'b0;
    bus.MOSI   = 1'b0;
    ptch_in    = 16'h0000;
    sample_stb = 1'b0;
    m_reset();
    wait_clk(4);
    check("reset_int", 32'(bus.INT), 32'd0);
    check("reset_miso", 32'(bus.MISO), 32'd0);
    rst = 1'b0;
    wait_clk(2 * HP);

    rd(7'h0F);
    wr(7'h0F, 8'h00);
    rd(7'h0F);
    wr(7'h0D, 8'h02);
    rd(7'h0D);
    rd(7'h05);

    sample_idle(16'h1234);
    rd(7'h22);
    rd(7'h23);

    // Strobe mid-read of PTCH_H: old high byte returned, new sample captured after.
    spi_frame(1'b1, 7'h23, 8'h00, 16, 5, 1, 16'hBEEF, -1);
    rd(7'h22);
    rd(7'h23);

    spi_frame(1'b0, 7'h03, 8'hA5, 10, -1, 0, 16'h0000, -1);
    rd(7'h03);

    // Two strobes in one frame: the later value wins.
    spi_frame(1'b1, 7'h05, 8'h00, 16, 3, 2, 16'h4000, -1);
    rd(7'h22);

    sample_idle(16'h5555);
    wr(7'h0D, 8'h00);
    sample_idle(16'h6666);

    wr(7'h03, 8'h5A);
    wr(7'h0D, 8'h02);
    sample_idle(16'h7777);
    spi_frame(1'b0, 7'h0D, 8'h02, 16, -1, 0, 16'h0000, 12);
    check("rst_mid_int", 32'(bus.INT), 32'd0);
    check("rst_mid_miso", 32'(bus.MISO), 32'd0);
    rd(7'h0D);
    rd(7'h03);
    rd(7'h23);
    rd(7'h0F);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = 7'($urandom_range(0, 14));
        2:       a = 7'h0D;
        3:       a = 7'h0F;
        4:       a = 7'h22 + 7'($urandom_range(0, 1));
        default: a = 7'($urandom_range(0, 127));
      endcase
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
      sb = -1;
      ns = 0;
      if ($urandom_range(0, 3) == 0) begin
        sb = int'($urandom_range(0, nb - 1));
        ns = int'($urandom_range(1, 2));
      end
      if ($urandom_range(0, 3) == 0) sample_idle(16'($urandom));
      spi_frame(1'($urandom_range(0, 1)), a, 8'($urandom), nb, sb, ns, 16'($urandom), -1);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/inert_spi_serf.md
# inert_spi_serf

Synthesizable SPI responder that models the inertial sensor end of the inertial-interface SPI link. It receives 16-bit mode-0 transactions from the SPI master, serves a small register map (configuration, WHO_AM_I, pitch data), and raises INT when a new pitch sample is latched. It sits on the sensor side of the SS_n/SCLK/MOSI/MISO/INT bus and is clocked by the same system clock as the master.

## Interface
Parameters:
- SYNC_STAGES, 3, metastability flops on SS_n, SCLK, MOSI (min 2)
- WHO_AM_I_VAL, 8'h6A, read-only value at address 0x0F

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- SS_n  in  1  slave select, active low
- SCLK  in  1  SPI clock, idle low (CPOL=0, CPHA=0)
- MOSI  in  1  master out, MSB first
- MISO  out  1  slave out, MSB first
- INT  out  1  new-sample interrupt, level, active high
- ptch_in  in  16  raw pitch sample from sensor core
- sample_stb  in  1  one-clk pulse: ptch_in valid

## Operation
- Frame: 16 SCLK periods inside one SS_n low window. Bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = write data (ignored on read).
- States: IDLE (SS_n high), SHIFT (SS_n low, counting bits), FINISH (one clk on SS_n rise: commit/discard), back to IDLE.
- SHIFT: each synchronized SCLK rise shifts MOSI into 16-bit rx register, bit counter +1 (saturates at 16).
- After 8th rise: address decoded; read data loaded into 8-bit tx register.
- Each SCLK fall after the 8th rise: MISO presents next tx bit, MSB first. MISO = 0 in IDLE and during first byte.
- Register map: 0x00–0x0E 8-bit R/W config regs (reset 0x00); 0x0F WHO_AM_I (read-only); 0x22 PTCH_L, 0x23 PTCH_H (read-only shadow); all other addresses read 0x00, writes ignored.
- FINISH with count == 16: write commits if R/W = 0 and address writable; if read of 0x23, INT clears. Count != 16: frame discarded, no side effects.
- Sample capture: sample_stb in IDLE copies ptch_in into shadow and sets INT if reg 0x0D bit1 = 1. sample_stb while not IDLE sets a pending flag; capture (latest ptch_in value held in a staging reg) occurs in FINISH. Multiple strobes overwrite staging.
- Simultaneous INT clear and capture in FINISH: capture wins, INT stays high.
- Reg 0x0D bit1 cleared by write: INT forced low at commit.

## Timing
- Reset: MISO = 0, INT = 0, all regs and shadow = 0, state IDLE, pending = 0.
- Input edge detection latency: SYNC_STAGES + 1 clk from pin edge.
- Required SCLK half-period ≥ SYNC_STAGES + 3 clk; SS_n fall to first SCLK rise ≥ SYNC_STAGES + 2 clk.
- MISO update: SYNC_STAGES + 2 clk after SCLK fall pin edge.
- Write commit, INT clear, deferred capture: 1 clk after synchronized SS_n rise.
- SS_n rise mid-frame: abort, no commit. rst mid-frame: immediate return to reset values.

## Structure
- Shared package inert_spi_pkg: register address constants (ADDR_INT_CFG = 7'h0D, ADDR_WHO = 7'h0F, ADDR_PTCH_L = 7'h22, ADDR_PTCH_H = 7'h23), state enum.
- One sub-module: spi_sync_edge (N-stage synchronizer plus rise/fall pulse outputs), instanced for SCLK and SS_n; MOSI uses the synchronizer only.

## Test plan
- Read 0x0F -> MISO returns 0x6A in bits 7:0; write 0x0F = 0x00 then reread -> still 0x6A.
- Write 0x0D = 0x02, read 0x0D -> 0x02; read 0x05 -> 0x00.
- With 0x0D = 0x02, sample_stb, ptch_in = 16'h1234 -> INT = 1; read 0x22 -> 0x34, INT still 1; read 0x23 -> 0x12, INT = 0 one clk after SS_n rise.
- sample_stb with ptch_in = 16'hBEEF during a read of 0x23 (old shadow 0x1234) -> read returns 0x12, shadow = 0xBEEF and INT = 1 after FINISH.
- Write 0x03 = 0xA5 with SS_n raised after 10 bits -> 0x03 remains 0x00, no INT change.
- Assert rst after 12 bits of a write to 0x0D -> all regs 0, INT = 0, MISO = 0; next full frame works normally.
